// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: byte width, output FIFO depth and header field layout.
package router_pkg;

   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 16;
   localparam int PKT_CNT_W  = 6;

   // Header byte layout: destination address in the low bits, payload length above it.
   localparam int ADDR_LSB = 0;
   localparam int ADDR_MSB = 1;
   localparam int LEN_LSB  = 2;
   localparam int LEN_MSB  = 7;

endpackage

// File: rtl/router_fifo_if.sv
// Handshake/data bundle between the router FSM/register stage (master) and one output FIFO (slave).
// Error flags exist only when ROUTER_FIFO_ERR_FLAG_EN is defined.
interface router_fifo_if #(parameter int WIDTH = router_pkg::DATA_W);

   logic             write_enb;
   logic             read_enb;
   logic             lfd_state;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             full;
   logic             empty;
`ifdef ROUTER_FIFO_ERR_FLAG_EN
   logic             overflow_err;
   logic             underflow_err;

   modport master (output write_enb, read_enb, lfd_state, data_in,
                   input  data_out, full, empty, overflow_err, underflow_err);
   modport slave  (input  write_enb, read_enb, lfd_state, data_in,
                   output data_out, full, empty, overflow_err, underflow_err);
`else
   modport master (output write_enb, read_enb, lfd_state, data_in,
                   input  data_out, full, empty);
   modport slave  (input  write_enb, read_enb, lfd_state, data_in,
                   output data_out, full, empty);
`endif

endinterface

// File: rtl/router_fifo_mem.sv
// Storage array for router_fifo: one synchronous write port, one asynchronous read port, no reset.
module router_fifo_mem #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/router_fifo.sv
// Per-destination router output FIFO with header tagging and read-side packet length tracking.
// Optional sticky overflow/underflow flags are enabled by ROUTER_FIFO_ERR_FLAG_EN.
module router_fifo
   import router_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          soft_reset,
   router_fifo_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [WIDTH:0]       rd_data;
   logic [WIDTH-1:0]     data_out_q;
   logic [PKT_CNT_W-1:0] pkt_cnt;
   logic                 full, empty, push, pop;

   // Extra pointer MSB distinguishes a full wrap from empty.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push  = bus.write_enb && !full;
   assign pop   = bus.read_enb && !empty;

   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.data_out = data_out_q;

   router_fifo_mem #(
      .WIDTH (WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push && !soft_reset),
      .waddr (wr_ptr[AW-1:0]),
      .wdata ({bus.lfd_state, bus.data_in}),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pkt_cnt    <= '0;
         data_out_q <= '0;
      end else if (soft_reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pkt_cnt    <= '0;
         data_out_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) begin
            rd_ptr     <= rd_ptr + PW'(1);
            data_out_q <= rd_data[WIDTH-1:0];
            // Header reload counts payload plus the trailing parity byte.
            if (rd_data[WIDTH])
               pkt_cnt <= rd_data[LEN_MSB:LEN_LSB] + PKT_CNT_W'(1);
            else if (pkt_cnt != '0)
               pkt_cnt <= pkt_cnt - PKT_CNT_W'(1);
         end else if (pkt_cnt == '0) begin
            data_out_q <= '0;
         end
      end
   end

`ifdef ROUTER_FIFO_ERR_FLAG_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (soft_reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.write_enb && full) overflow_q  <= 1'b1;
         if (bus.read_enb && empty) underflow_q <= 1'b1;
      end
   end

   assign bus.overflow_err  = overflow_q;
   assign bus.underflow_err = underflow_q;
`endif

endmodule
